// File: rtl/mic_control_pkg.sv
// Shared constants for the I2S microphone capture block.
// Divider width, sample width and the divider counts at which the
// receiver samples, latches each channel and strobes a new pair.
package mic_control_pkg;

  localparam int DIV_W    = 10;
  localparam int SAMPLE_W = 16;

  // Sample point inside one sck period: two clk after the sck rising edge,
  // which covers the two-flop synchronizer delay.
  localparam logic [3:0] SAMPLE_PHASE = 4'd10;

  // Slot 0 of each half-frame is the I2S one-bit delay; slots 1..16 carry
  // the sixteen most significant bits of the ADC word.
  localparam logic [4:0] FIRST_SLOT = 5'd1;
  localparam logic [4:0] LAST_SLOT  = 5'd16;

  localparam logic [DIV_W-1:0] LEFT_LATCH  = 10'd266;
  localparam logic [DIV_W-1:0] RIGHT_LATCH = 10'd778;
  localparam logic [DIV_W-1:0] STROBE_CNT  = 10'd779;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/i2s_rx_clkgen.sv
// Free-running frame divider and ADC clock generation.
// Ports:
//   clk, rst_n      system clock, synchronous active-low reset
//   en              advance the divider; low freezes it and silences clocks
//   cnt             current divider value (position within the 1024-clk frame)
//   mclk, sck, lrck ADC clocks, registered so they line up with cnt bits 1, 3, 9
module i2s_rx_clkgen
  import mic_control_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [DIV_W-1:0] cnt,
  output logic             mclk,
  output logic             sck,
  output logic             lrck
);

  logic [DIV_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (en) cnt_nxt = cnt + 1'b1;
  end

  // Clocks are registered from the next divider value, so while running each
  // clock equals its cnt bit in the same cycle; lrck therefore changes together
  // with the sck falling edge at cnt[3:0]==0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      mclk <= 1'b0;
      sck  <= 1'b0;
      lrck <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      mclk <= en & cnt_nxt[1];
      sck  <= en & cnt_nxt[3];
      lrck <= en & cnt_nxt[9];
    end
  end

endmodule

// File: rtl/mic_control.sv
// I2S receiver for a stereo ADC: generates the ADC clocks, deserializes the
// MSB-first data stream and presents one left/right pair per 1024-clk frame.
// Ports:
//   clk, rst_n                 system clock, synchronous active-low reset
//   en                         capture enable
//   audio_mclk/sck/lrck        ADC master, bit and word-select clocks
//   audio_sdout                ADC serial data (asynchronous)
//   audio_out_left/right       last complete sample pair, two's complement
//   out_valid                  one-cycle strobe when a new pair is presented
module mic_control
  import mic_control_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  output logic                       audio_mclk,
  output logic                       audio_lrck,
  output logic                       audio_sck,
  input  logic                       audio_sdout,
  output logic signed [SAMPLE_W-1:0] audio_out_left,
  output logic signed [SAMPLE_W-1:0] audio_out_right,
  output logic                       out_valid
);

  logic [DIV_W-1:0] cnt;
  logic [4:0]       slot;
  logic             sdout_p0;
  logic             sdout_p1;
  logic             sample_now;
  logic             frame_ok;
  sample_t          shift_q;
  sample_t          shift_nxt;
  sample_t          left_hold;
  sample_t          left_hold_nxt;
  sample_t          right_hold;
  sample_t          right_hold_nxt;

  i2s_rx_clkgen u_clkgen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .cnt   (cnt),
    .mclk  (audio_mclk),
    .sck   (audio_sck),
    .lrck  (audio_lrck)
  );

  assign slot = cnt[8:4];

  always_comb begin
    sample_now     = en && (cnt[3:0] == SAMPLE_PHASE) &&
                     (slot >= FIRST_SLOT) && (slot <= LAST_SLOT);
    shift_nxt      = shift_q;
    if (sample_now) shift_nxt = {shift_q[SAMPLE_W-2:0], sdout_p1};
    // Holding registers take the value including the slot-16 bit shifted on
    // the same edge.
    left_hold_nxt  = left_hold;
    right_hold_nxt = right_hold;
    if (en && (cnt == LEFT_LATCH))  left_hold_nxt  = shift_nxt;
    if (en && (cnt == RIGHT_LATCH)) right_hold_nxt = shift_nxt;
  end

  // Stage p0/p1: synchronizer; then shifter, holding and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sdout_p0        <= 1'b0;
      sdout_p1        <= 1'b0;
      shift_q         <= '0;
      left_hold       <= '0;
      right_hold      <= '0;
      frame_ok        <= 1'b0;
      audio_out_left  <= '0;
      audio_out_right <= '0;
      out_valid       <= 1'b0;
    end else begin
      sdout_p0   <= audio_sdout;
      sdout_p1   <= sdout_p0;
      shift_q    <= shift_nxt;
      left_hold  <= left_hold_nxt;
      right_hold <= right_hold_nxt;
      // A frame is trusted only if en stayed high from its cnt==0 onwards;
      // any low cycle taints it until the next frame start.
      if (!en)              frame_ok <= 1'b0;
      else if (cnt == '0)   frame_ok <= 1'b1;
      out_valid <= 1'b0;
      if (en && frame_ok && (cnt == STROBE_CNT - 1'b1)) begin
        out_valid       <= 1'b1;
        audio_out_left  <= left_hold_nxt;
        audio_out_right <= right_hold_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mic_control.sv
`timescale 1ns/1ps
module tb_mic_control;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic               audio_mclk;
  logic               audio_lrck;
  logic               audio_sck;
  logic               audio_sdout = 1'b0;
  logic signed [15:0] audio_out_left;
  logic signed [15:0] audio_out_right;
  logic               out_valid;

  int passes = 0;
  int total  = 0;

  logic [15:0] cur_l = 16'h0000;
  logic [15:0] cur_r = 16'h0000;
  logic [31:0] sb_q[$];

  mic_control dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .audio_mclk      (audio_mclk),
    .audio_lrck      (audio_lrck),
    .audio_sck       (audio_sck),
    .audio_sdout     (audio_sdout),
    .audio_out_left  (audio_out_left),
    .audio_out_right (audio_out_right),
    .out_valid       (out_valid)
  );

  always #5 clk = ~clk;

  // ADC model: 24-bit I2S words, data changes after each sck falling edge,
  // one delay slot after every lrck change, MSB first, low byte 8'hFF.
  int          bit_idx = 0;
  logic        lrck_prev = 1'b0;
  logic [23:0] word;
  always @(negedge audio_sck or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx   = 0;
      lrck_prev = 1'b0;
    end else begin
      #2;
      if (audio_lrck != lrck_prev) begin
        bit_idx   = 0;
        lrck_prev = audio_lrck;
      end else begin
        bit_idx++;
      end
      word = audio_lrck ? {cur_r, 8'hFF} : {cur_l, 8'hFF};
      audio_sdout = (bit_idx >= 1 && bit_idx <= 24) ? word[24-bit_idx] : 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input int max_cyc, output int n, output bit got, output bit held_ok);
    logic [15:0] l0, r0;
    l0 = audio_out_left;
    r0 = audio_out_right;
    n = 0; got = 1'b0; held_ok = 1'b1;
    while (n < max_cyc && !got) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) got = 1'b1;
      else if (audio_out_left !== l0 || audio_out_right !== r0) held_ok = 1'b0;
    end
  endtask

  // exp_n < 0 skips the latency comparison (phase unknown).
  task automatic expect_strobe(input string tag, input int exp_n, input int offset);
    int n; bit got; bit held; logic [31:0] e;
    wait_strobe((exp_n < 0) ? 1100 : exp_n + 64, n, got, held);
    check({tag, "_got"}, 16'(got), 16'd1);
    if (exp_n >= 0) check({tag, "_latency"}, 16'(n + offset), 16'(exp_n));
    check({tag, "_held"}, 16'(held), 16'd1);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
    check({tag, "_left"}, audio_out_left, e[31:16]);
    check({tag, "_right"}, audio_out_right, e[15:0]);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 16'(out_valid), 16'd0);
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return audio_mclk;
      1:       return audio_sck;
      default: return audio_lrck;
    endcase
  endfunction

  task automatic measure(input int sel, output int period, output bit align_ok);
    logic prev, cur, sck_prev;
    bit started;
    int n;
    period = 0; align_ok = 1'b1; started = 1'b0; n = 0;
    prev = pick(sel);
    sck_prev = audio_sck;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      cur = pick(sel);
      if (sel == 2 && cur != prev &&
          !(audio_sck == 1'b0 && sck_prev == 1'b1 && audio_mclk == 1'b0))
        align_ok = 1'b0;
      if (started) n++;
      if (!prev && cur) begin
        if (started) begin
          period = n;
          break;
        end
        started = 1'b1;
        n = 0;
      end
      prev = cur;
      sck_prev = audio_sck;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mclk"},  16'(audio_mclk), 16'd0);
    check({tag, "_sck"},   16'(audio_sck),  16'd0);
    check({tag, "_lrck"},  16'(audio_lrck), 16'd0);
    check({tag, "_valid"}, 16'(out_valid),  16'd0);
    check({tag, "_left"},  audio_out_left,  16'h0000);
    check({tag, "_right"}, audio_out_right, 16'h0000);
  endtask

  initial begin
    int  per;
    bit  aok;
    bit  bad;

    // Power-up reset with en high.
    en = 1'b1;
    cur_l = 16'h8001;
    cur_r = 16'h7FFE;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");

    // First strobe, latency counted from the last edge that sampled rst_n low.
    rst_n = 1'b1;
    sb_q.push_back({16'h8001, 16'h7FFE});
    expect_strobe("first", 780, 1);

    // Steady state: one strobe per 1024 clk (1023 after the pulse check).
    sb_q.push_back({16'h8001, 16'h7FFE});
    expect_strobe("steady", 1023, 0);

    // Clock periods and lrck alignment with the sck falling edge.
    measure(0, per, aok);
    check("mclk_period", 16'(per), 16'd4);
    measure(1, per, aok);
    check("sck_period", 16'(per), 16'd16);
    measure(2, per, aok);
    check("lrck_period", 16'(per), 16'd1024);
    check("lrck_align", 16'(aok), 16'd1);

    sb_q.push_back({16'h8001, 16'h7FFE});
    expect_strobe("resync", -1, 0);

    // Alternating patterns, one per frame.
    cur_l = 16'hAAAA; cur_r = 16'h5555;
    sb_q.push_back({16'hAAAA, 16'h5555});
    expect_strobe("alt_a", 1023, 0);
    cur_l = 16'h5555; cur_r = 16'hAAAA;
    sb_q.push_back({16'h5555, 16'hAAAA});
    expect_strobe("alt_b", 1023, 0);

    // Reset mid-frame at cnt==500.
    repeat (744) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midrst");
    cur_l = 16'h1234; cur_r = 16'hFEDC;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.push_back({16'h1234, 16'hFEDC});
    expect_strobe("postrst", 780, 1);

    // Drop en for 100 clk at cnt==300.
    repeat (544) @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk); #1;
    check("endrop_mclk", 16'(audio_mclk), 16'd0);
    check("endrop_sck",  16'(audio_sck),  16'd0);
    check("endrop_lrck", 16'(audio_lrck), 16'd0);
    cur_l = 16'h0F0F; cur_r = 16'hF0F0;
    bad = 1'b0;
    for (int i = 0; i < 99; i++) begin
      @(posedge clk); #1;
      if (out_valid || audio_mclk || audio_sck || audio_lrck ||
          audio_out_left !== 16'h1234 || audio_out_right !== 16'hFEDC)
        bad = 1'b1;
    end
    check("endrop_quiet", 16'(bad), 16'd0);
    en = 1'b1;
    sb_q.push_back({16'h0F0F, 16'hF0F0});
    expect_strobe("endrop_next", 1503, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
